// File: rtl/alu_pkg.sv
// Shared opcodes, FSM encoding and helpers for the ALU issue controller.
package alu_pkg;

  localparam int DATA_W_DEF = 32;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0011;
  localparam logic [3:0] OP_OR  = 4'b0100;
  localparam logic [3:0] OP_XOR = 4'b0110;
  localparam logic [3:0] OP_NOT = 4'b0111;
  localparam logic [3:0] OP_SHL = 4'b1000;
  localparam logic [3:0] OP_SHR = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_e;

  function automatic logic is_legal_op(input logic [3:0] op);
    logic legal;
    legal = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_MUL,
      OP_AND, OP_OR, OP_XOR,
      OP_NOT, OP_SHL, OP_SHR: legal = 1'b1;
      default:                legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// Register file: two sync-reset write ports (writeback beats host),
// three combinational read ports.
module alu_regfile #(
  parameter int DATA_W = 32,
  parameter int NREG   = 8,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wb_we,
  input  logic [REG_AW-1:0] i_wb_addr,
  input  logic [DATA_W-1:0] i_wb_data,
  input  logic              i_host_we,
  input  logic [REG_AW-1:0] i_host_addr,
  input  logic [DATA_W-1:0] i_host_data,
  input  logic [REG_AW-1:0] i_rs1_addr,
  output logic [DATA_W-1:0] o_rs1_data,
  input  logic [REG_AW-1:0] i_rs2_addr,
  output logic [DATA_W-1:0] o_rs2_data,
  input  logic [REG_AW-1:0] i_dbg_addr,
  output logic [DATA_W-1:0] o_dbg_data
);

  logic [DATA_W-1:0] r_mem [NREG];
  logic              w_host_ok;

  // A host write colliding with writeback on the same index is dropped.
  assign w_host_ok = i_host_we &&
                     !(i_wb_we && (i_wb_addr == i_host_addr));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (i_wb_we) begin
        r_mem[i_wb_addr] <= i_wb_data;
      end
      if (w_host_ok) begin
        r_mem[i_host_addr] <= i_host_data;
      end
    end
  end

  assign o_rs1_data = r_mem[i_rs1_addr];
  assign o_rs2_data = r_mem[i_rs2_addr];
  assign o_dbg_data = r_mem[i_dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue sequencer for the external 32-bit ALU: IDLE -> EXEC -> WB,
// operands read at handshake, result written back in WB.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NREG   = 8,
  parameter int REG_AW = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [4+3*REG_AW-1:0] instr,
  input  logic                  host_we,
  input  logic [REG_AW-1:0]     host_waddr,
  input  logic [DATA_W-1:0]     host_wdata,
  input  logic [REG_AW-1:0]     dbg_raddr,
  output logic [DATA_W-1:0]     dbg_rdata,
  output logic [DATA_W-1:0]     alu_op1,
  output logic [DATA_W-1:0]     alu_op2,
  output logic [3:0]            alu_opcode,
  input  logic [DATA_W-1:0]     alu_result,
  output logic                  res_valid,
  output logic [DATA_W-1:0]     res_data,
  output logic [REG_AW-1:0]     res_rd,
  output logic                  illegal_op
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic              w_accept;
  logic              w_reject;
  logic              w_legal;
  logic              w_wb_we;
  logic [3:0]        w_op;
  logic [REG_AW-1:0] w_rd;
  logic [REG_AW-1:0] w_rs1;
  logic [REG_AW-1:0] w_rs2;
  logic [DATA_W-1:0] w_rs1_data;
  logic [DATA_W-1:0] w_rs2_data;

  logic [DATA_W-1:0] r_op1;
  logic [DATA_W-1:0] r_op2;
  logic [3:0]        r_opcode;
  logic [REG_AW-1:0] r_rd;
  logic [DATA_W-1:0] r_res_data;
  logic              r_illegal;

  assign {w_op, w_rd, w_rs1, w_rs2} = instr;
  assign w_legal = is_legal_op(w_op);

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (instr_valid) begin
          if (w_legal) begin
            w_accept    = 1'b1;
            w_state_nxt = ST_EXEC;
          end else begin
            w_reject    = 1'b1;
          end
        end
      end
      ST_EXEC: w_state_nxt = ST_WB;
      ST_WB:   w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_op1      <= '0;
      r_op2      <= '0;
      r_opcode   <= 4'b0000;
      r_rd       <= '0;
      r_res_data <= '0;
      r_illegal  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_illegal <= w_reject;
      if (w_accept) begin
        r_opcode <= w_op;
        r_rd     <= w_rd;
        r_op1    <= w_rs1_data;
        r_op2    <= w_rs2_data;
      end
      if (r_state == ST_EXEC) begin
        r_res_data <= alu_result;
      end
    end
  end

  assign w_wb_we = (r_state == ST_WB);

  alu_regfile #(
    .DATA_W (DATA_W),
    .NREG   (NREG),
    .REG_AW (REG_AW)
  ) u_regfile (
    .clk         (clk),
    .rst         (rst),
    .i_wb_we     (w_wb_we),
    .i_wb_addr   (r_rd),
    .i_wb_data   (r_res_data),
    .i_host_we   (host_we),
    .i_host_addr (host_waddr),
    .i_host_data (host_wdata),
    .i_rs1_addr  (w_rs1),
    .o_rs1_data  (w_rs1_data),
    .i_rs2_addr  (w_rs2),
    .o_rs2_data  (w_rs2_data),
    .i_dbg_addr  (dbg_raddr),
    .o_dbg_data  (dbg_rdata)
  );

  assign instr_ready = (r_state == ST_IDLE);
  assign res_valid   = w_wb_we;
  assign res_data    = r_res_data;
  assign res_rd      = r_rd;
  assign alu_op1     = r_op1;
  assign alu_op2     = r_op2;
  assign alu_opcode  = r_opcode;
  assign illegal_op  = r_illegal;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a behavioural ALU attached.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [12:0] instr;
  logic        host_we;
  logic [2:0]  host_waddr;
  logic [31:0] host_wdata;
  logic [2:0]  dbg_raddr;
  logic [31:0] dbg_rdata;
  logic [31:0] alu_op1;
  logic [31:0] alu_op2;
  logic [3:0]  alu_opcode;
  logic [31:0] alu_result;
  logic        res_valid;
  logic [31:0] res_data;
  logic [2:0]  res_rd;
  logic        illegal_op;

  int errors = 0;
  int checks = 0;
  logic [31:0] m_reg [8];

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .host_we     (host_we),
    .host_waddr  (host_waddr),
    .host_wdata  (host_wdata),
    .dbg_raddr   (dbg_raddr),
    .dbg_rdata   (dbg_rdata),
    .alu_op1     (alu_op1),
    .alu_op2     (alu_op2),
    .alu_opcode  (alu_opcode),
    .alu_result  (alu_result),
    .res_valid   (res_valid),
    .res_data    (res_data),
    .res_rd      (res_rd),
    .illegal_op  (illegal_op)
  );

  // External combinational ALU.
  always_comb begin
    logic [63:0] prod;
    prod = {32'd0, alu_op1} * {32'd0, alu_op2};
    alu_result = 32'd0;
    case (alu_opcode)
      4'b0000: alu_result = alu_op1 + alu_op2;
      4'b0001: alu_result = alu_op1 - alu_op2;
      4'b0010: alu_result = prod[31:0];
      4'b0011: alu_result = alu_op1 & alu_op2;
      4'b0100: alu_result = alu_op1 | alu_op2;
      4'b0110: alu_result = alu_op1 ^ alu_op2;
      4'b0111: alu_result = {31'd0, alu_op1 == 32'd0};
      4'b1000: alu_result = {alu_op1[30:0], 1'b0};
      4'b1001: alu_result = {1'b0, alu_op1[31:1]};
      default: alu_result = 32'd0;
    endcase
  end

  // Reference arithmetic, modulo 2^32.
  function automatic logic [31:0] ref_alu(input logic [3:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    longint unsigned ua, ub, r;
    ua = longint'(a);
    ub = longint'(b);
    case (op)
      4'd0: r = ua + ub;
      4'd1: r = ua + (64'h1_0000_0000 - ub);
      4'd2: r = ua * ub;
      4'd3: r = longint'(a & b);
      4'd4: r = longint'(a | b);
      4'd6: r = longint'(a ^ b);
      4'd7: r = (ua == 0) ? 1 : 0;
      4'd8: r = ua * 2;
      4'd9: r = ua / 2;
      default: r = 0;
    endcase
    return r[31:0];
  endfunction

  function automatic logic [12:0] mk(input logic [3:0] op, input logic [2:0] rd,
                                     input logic [2:0] rs1, input logic [2:0] rs2);
    return {op, rd, rs1, rs2};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [2:0] a, input logic [31:0] d);
    host_we    = 1'b1;
    host_waddr = a;
    host_wdata = d;
    tick();
    host_we    = 1'b0;
    m_reg[a]   = d;
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 8; i++) begin
      dbg_raddr = 3'(i);
      #1;
      chk($sformatf("%s_r%0d", tag, i), dbg_rdata, m_reg[i]);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [2:0] rd,
                       input logic [2:0] rs1, input logic [2:0] rs2,
                       output logic [31:0] got);
    logic [31:0] a, b, exp;
    int n;
    n = 0;
    got = 32'd0;
    while (!instr_ready && n < 10) begin
      tick();
      n++;
    end
    if (!instr_ready) begin
      chk("ready_wait", 32'(instr_ready), 32'd1);
      return;
    end
    a   = m_reg[rs1];
    b   = m_reg[rs2];
    exp = ref_alu(op, a, b);
    instr       = mk(op, rd, rs1, rs2);
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    chk("exec_ready", 32'(instr_ready), 32'd0);
    chk("exec_resv", 32'(res_valid), 32'd0);
    chk("exec_op1", alu_op1, a);
    chk("exec_op2", alu_op2, b);
    chk("exec_opc", 32'(alu_opcode), 32'(op));
    tick();
    chk("wb_valid", 32'(res_valid), 32'd1);
    chk("wb_ready", 32'(instr_ready), 32'd0);
    chk("wb_data", res_data, exp);
    chk("wb_rd", 32'(res_rd), 32'(rd));
    got = res_data;
    tick();
    m_reg[rd] = exp;
    chk("idle_ready", 32'(instr_ready), 32'd1);
    chk("idle_resv", 32'(res_valid), 32'd0);
    chk("idle_hold", res_data, exp);
    dbg_raddr = rd;
    #1;
    chk("idle_rd", dbg_rdata, exp);
  endtask

  task automatic illegal(input logic [3:0] op, input logic [2:0] rd);
    instr       = mk(op, rd, 3'd1, 3'd2);
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    chk("ill_pulse", 32'(illegal_op), 32'd1);
    chk("ill_ready", 32'(instr_ready), 32'd1);
    chk("ill_resv", 32'(res_valid), 32'd0);
    tick();
    chk("ill_pulse_end", 32'(illegal_op), 32'd0);
    chk("ill_resv2", 32'(res_valid), 32'd0);
    dbg_raddr = rd;
    #1;
    chk("ill_rd", dbg_rdata, m_reg[rd]);
  endtask

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [2:0]  rd;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [11];

  initial begin
    logic [31:0] got;
    logic [31:0] expq [$];
    logic [2:0]  rdq [$];
    logic [3:0]  bop [3];
    logic [2:0]  brd [3];
    logic [2:0]  brs1 [3];
    logic [2:0]  brs2 [3];
    logic [3:0]  legal [9];
    logic [3:0]  bad [7];
    int k;

    tbl[0]  = '{"add",   4'b0000, 3'd3, 3'd1, 3'd2, 32'd5, 32'd3, 32'd8};
    tbl[1]  = '{"sub",   4'b0001, 3'd4, 3'd1, 3'd2, 32'd1, 32'd2, 32'hFFFF_FFFF};
    tbl[2]  = '{"mul",   4'b0010, 3'd5, 3'd4, 3'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1};
    tbl[3]  = '{"and",   4'b0011, 3'd3, 3'd1, 3'd2, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200};
    tbl[4]  = '{"or",    4'b0100, 3'd3, 3'd1, 3'd2, 32'hF0F0_1234, 32'h0FF0_FF00, 32'hFFF0_FF34};
    tbl[5]  = '{"xor",   4'b0110, 3'd3, 3'd1, 3'd2, 32'hF0F0_1234, 32'h0FF0_FF00, 32'hFF00_ED34};
    tbl[6]  = '{"shl",   4'b1000, 3'd7, 3'd6, 3'd2, 32'h8000_0001, 32'd9, 32'h0000_0002};
    tbl[7]  = '{"shr",   4'b1001, 3'd7, 3'd6, 3'd2, 32'h8000_0001, 32'd9, 32'h4000_0000};
    tbl[8]  = '{"not0",  4'b0111, 3'd7, 3'd0, 3'd2, 32'd0, 32'd9, 32'd1};
    tbl[9]  = '{"not6",  4'b0111, 3'd7, 3'd6, 3'd2, 32'h8000_0001, 32'd9, 32'd0};
    tbl[10] = '{"addov", 4'b0000, 3'd3, 3'd1, 3'd2, 32'hFFFF_FFFF, 32'd2, 32'd1};

    legal = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd7, 4'd8, 4'd9};
    bad   = '{4'd5, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};

    for (int i = 0; i < 8; i++) m_reg[i] = 32'd0;
    rst         = 1'b1;
    instr_valid = 1'b0;
    instr       = '0;
    host_we     = 1'b0;
    host_waddr  = '0;
    host_wdata  = '0;
    dbg_raddr   = '0;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_ready", 32'(instr_ready), 32'd1);
    chk("rst_resv", 32'(res_valid), 32'd0);
    chk("rst_resdata", res_data, 32'd0);
    chk("rst_resrd", 32'(res_rd), 32'd0);
    chk("rst_illegal", 32'(illegal_op), 32'd0);
    chk("rst_op1", alu_op1, 32'd0);
    chk("rst_op2", alu_op2, 32'd0);
    chk("rst_opc", 32'(alu_opcode), 32'd0);
    check_regs("rst");

    // Directed vectors.
    for (int i = 0; i < 11; i++) begin
      preload(tbl[i].rs1, tbl[i].a);
      preload(tbl[i].rs2, tbl[i].b);
      issue(tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, got);
      chk(tbl[i].name, got, tbl[i].exp);
    end

    // Dependent chain: sub then mul of its own result.
    preload(3'd1, 32'd1);
    preload(3'd2, 32'd2);
    issue(4'b0001, 3'd4, 3'd1, 3'd2, got);
    issue(4'b0010, 3'd5, 3'd4, 3'd4, got);
    dbg_raddr = 3'd5;
    #1;
    chk("chain_r5", dbg_rdata, 32'd1);

    // Illegal opcodes leave everything untouched.
    illegal(4'b0101, 3'd3);
    illegal(4'b1111, 3'd5);
    check_regs("ill");

    // Back-to-back with instr_valid held.
    preload(3'd1, 32'h0000_1111);
    preload(3'd2, 32'h0000_0022);
    bop  = '{4'b0000, 4'b0110, 4'b0001};
    brd  = '{3'd3, 3'd4, 3'd5};
    brs1 = '{3'd1, 3'd3, 3'd4};
    brs2 = '{3'd2, 3'd1, 3'd2};
    k = 0;
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("b2b_ready_c%0d", c), 32'(instr_ready), 32'(c % 3 == 0));
      chk($sformatf("b2b_resv_c%0d", c), 32'(res_valid), 32'(c % 3 == 2));
      if (res_valid && expq.size() > 0) begin
        chk($sformatf("b2b_data_c%0d", c), res_data, expq[0]);
        chk($sformatf("b2b_rd_c%0d", c), 32'(res_rd), 32'(rdq[0]));
        m_reg[rdq[0]] = expq[0];
        void'(expq.pop_front());
        void'(rdq.pop_front());
      end
      if (instr_ready) begin
        if (k < 3) begin
          expq.push_back(ref_alu(bop[k], m_reg[brs1[k]], m_reg[brs2[k]]));
          rdq.push_back(brd[k]);
          instr       = mk(bop[k], brd[k], brs1[k], brs2[k]);
          instr_valid = 1'b1;
          k++;
        end else begin
          instr_valid = 1'b0;
        end
      end
      tick();
    end
    instr_valid = 1'b0;
    chk("b2b_drained", 32'(expq.size()), 32'd0);
    check_regs("b2b");

    // Host write to rs1 in handshake cycle, then host write to rd in WB.
    preload(3'd1, 32'd10);
    preload(3'd2, 32'd20);
    instr       = mk(4'b0000, 3'd3, 3'd1, 3'd2);
    instr_valid = 1'b1;
    host_we     = 1'b1;
    host_waddr  = 3'd1;
    host_wdata  = 32'h0000_AAAA;
    tick();
    instr_valid = 1'b0;
    host_we     = 1'b0;
    m_reg[1]    = 32'h0000_AAAA;
    chk("hs_host_op1", alu_op1, 32'd10);
    tick();
    chk("hw_wb_valid", 32'(res_valid), 32'd1);
    chk("hw_wb_data", res_data, 32'd30);
    host_we    = 1'b1;
    host_waddr = 3'd3;
    host_wdata = 32'hDEAD_BEEF;
    tick();
    host_we  = 1'b0;
    m_reg[3] = 32'd30;
    check_regs("hostwb");

    // Reset during EXEC aborts the operation.
    preload(3'd6, 32'h0000_0055);
    instr       = mk(4'b0000, 3'd6, 3'd1, 3'd2);
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    chk("abort_exec", 32'(instr_ready), 32'd0);
    rst = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) m_reg[i] = 32'd0;
    chk("abort_resv", 32'(res_valid), 32'd0);
    chk("abort_ready", 32'(instr_ready), 32'd1);
    chk("abort_opc", 32'(alu_opcode), 32'd0);
    chk("abort_op1", alu_op1, 32'd0);
    rst = 1'b0;
    tick();
    chk("abort_resv2", 32'(res_valid), 32'd0);
    chk("abort_ready2", 32'(instr_ready), 32'd1);
    chk("abort_resdata", res_data, 32'd0);
    check_regs("abort");

    // Randomised traffic against the model.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        preload(3'($urandom_range(0, 7)), $urandom);
      end
      if ($urandom_range(0, 7) == 0) begin
        illegal(bad[$urandom_range(0, 6)], 3'($urandom_range(0, 7)));
      end else begin
        issue(legal[$urandom_range(0, 8)], 3'($urandom_range(0, 7)),
              3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), got);
      end
    end
    check_regs("rand");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
